// File: rtl/word_packer_pkg.sv
// Shared types for the word packer: FSM state encoding and lane-count width helper.
package word_packer_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FULL_WAIT  = 2'd1,
        FLUSH_WAIT = 2'd2
    } wp_state_e;

    // Width needed to hold a lane count of 0..pack inclusive.
    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Pops IN_WIDTH-bit FIFO entries and packs PACK of them (lane 0 at the LSB) into one
// wide word behind a one-entry valid/ready holding register; flush emits a partial word.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int PACK     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [IN_WIDTH-1:0]        fifo_dout,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IN_WIDTH*PACK-1:0]   out_data,
    output logic [cnt_w(PACK)-1:0]     out_count
);

    localparam int            CW       = cnt_w(PACK);
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK);

    wp_state_e                         r_state;
    logic [PACK-1:0][IN_WIDTH-1:0]     r_acc;
    logic [CW-1:0]                     r_lane_cnt;
    logic                              r_pend;
    logic                              r_flush_pend;
    logic [IN_WIDTH*PACK-1:0]          r_out_data;
    logic [CW-1:0]                     r_out_count;
    logic                              r_out_valid;

    wp_state_e                         w_nxt_state;
    logic [PACK-1:0][IN_WIDTH-1:0]     w_acc_cap;
    logic [PACK-1:0][IN_WIDTH-1:0]     w_nxt_acc;
    logic [CW-1:0]                     w_cnt_cap;
    logic [CW-1:0]                     w_nxt_cnt;
    logic                              w_nxt_flush_pend;
    logic [IN_WIDTH*PACK-1:0]          w_nxt_out_data;
    logic [CW-1:0]                     w_nxt_out_count;
    logic                              w_nxt_out_valid;
    logic                              w_out_free;
    logic [CW:0]                       w_inflight;

    // Lanes already held plus the read in flight must leave room for one more lane.
    assign w_inflight = {1'b0, r_lane_cnt} + {{CW{1'b0}}, r_pend};
    assign fifo_rd_en = rst_n && !fifo_empty && (r_state == FILL)
                        && (w_inflight < {1'b0, FULL_CNT});

    assign w_out_free = !r_out_valid || out_ready;
    assign w_cnt_cap  = r_lane_cnt + CW'(r_pend);

    always_comb begin
        w_acc_cap = r_acc;
        for (int k = 0; k < PACK; k++) begin
            if (r_pend && (r_lane_cnt == CW'(k))) begin
                w_acc_cap[k] = fifo_dout;
            end
        end
    end

    always_comb begin
        w_nxt_acc        = w_acc_cap;
        w_nxt_cnt        = w_cnt_cap;
        w_nxt_flush_pend = r_flush_pend || flush;
        w_nxt_out_data   = r_out_data;
        w_nxt_out_count  = r_out_count;
        w_nxt_out_valid  = r_out_valid && !out_ready;
        w_nxt_state      = FILL;

        if (w_cnt_cap == FULL_CNT) begin
            // A complete word always goes out before any pending flush is looked at.
            if (w_out_free) begin
                w_nxt_out_data  = w_acc_cap;
                w_nxt_out_count = FULL_CNT;
                w_nxt_out_valid = 1'b1;
                w_nxt_acc       = '0;
                w_nxt_cnt       = '0;
            end
        end else if (r_flush_pend && !r_pend) begin
            if (r_lane_cnt == '0) begin
                w_nxt_flush_pend = 1'b0;
            end else if (w_out_free) begin
                // acc lanes above lane_cnt are kept zero, so the partial word is clean.
                w_nxt_out_data   = r_acc;
                w_nxt_out_count  = r_lane_cnt;
                w_nxt_out_valid  = 1'b1;
                w_nxt_acc        = '0;
                w_nxt_cnt        = '0;
                w_nxt_flush_pend = 1'b0;
            end
        end

        if (w_nxt_cnt == FULL_CNT) begin
            w_nxt_state = FULL_WAIT;
        end else if (w_nxt_flush_pend) begin
            w_nxt_state = FLUSH_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_acc        <= '0;
            r_lane_cnt   <= '0;
            r_pend       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_acc        <= w_nxt_acc;
            r_lane_cnt   <= w_nxt_cnt;
            r_pend       <= fifo_rd_en;
            r_flush_pend <= w_nxt_flush_pend;
            r_out_data   <= w_nxt_out_data;
            r_out_count  <= w_nxt_out_count;
            r_out_valid  <= w_nxt_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: a FIFO model feeds bytes, expected words are queued
// as stimulus is issued and compared when the DUT hands a word over.
module tb_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [31:0] exp_d [0:63];
    logic [2:0]  exp_c [0:63];
    int          exp_wr = 0;
    int          exp_rd = 0;

    logic        hold = 1'b0;
    logic [31:0] hd = '0;
    logic [2:0]  hc = '0;

    word_packer #(.IN_WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: data appears on fifo_dout the cycle after fifo_rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                chk("rd_while_empty", 1, 0);
            end else begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_cnt", out_count, hc);
            end
            if (out_valid && out_ready) begin
                if (exp_rd == exp_wr) begin
                    chk("unexp_word", {out_count, out_data}, 0);
                end else begin
                    chk("word_data", out_data, exp_d[exp_rd]);
                    chk("word_cnt", out_count, exp_c[exp_rd]);
                    exp_rd <= exp_rd + 1;
                end
            end
            hold <= out_valid && !out_ready;
            hd   <= out_data;
            hc   <= out_count;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        exp_d[exp_wr] = d;
        exp_c[exp_wr] = c;
        exp_wr = exp_wr + 1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_rd != exp_wr && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, exp_rd, exp_wr);
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", out_count, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Basic full word, first-word latency
        out_ready = 1'b1;
        expect_word(32'h44332211, 3'd4);
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) chk("t1_rd_en", fifo_rd_en, (c < 4));
            chk("t1_vld", out_valid, (c == 5));
            if (c == 5) begin
                chk("t1_data", out_data, 32'h44332211);
                chk("t1_cnt", out_count, 4);
            end
            step(1);
        end
        drain("t1_drain");

        // Backpressure: second word parks in acc, reads stop while a byte waits
        out_ready = 1'b0;
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        for (int i = 1; i <= 9; i++) load(8'(i));
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 10 || c == 11) chk("t2_full_rd", fifo_rd_en, 0);
            if (c == 12) chk("t2_word1", out_data, 32'h04030201);
            if (c == 13) begin
                chk("t2_word2_vld", out_valid, 1);
                chk("t2_word2", out_data, 32'h08070605);
            end
            step(1);
            if (c == 11) out_ready = 1'b1;
        end
        step(3);
        expect_word(32'h00000009, 3'd1);
        pulse_flush();
        drain("t2_drain");

        // Partial flush, then a clean full word proves lane_cnt cleared
        expect_word(32'h0000BBAA, 3'd2);
        load(8'hAA); load(8'hBB);
        step(4);
        pulse_flush();
        drain("t3_drain");
        expect_word(32'hC4C3C2C1, 3'd4);
        load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
        drain("t3b_drain");

        // Flush with empty accumulator: no word, flush_pend blocks reads one cycle
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        load(8'h5A);
        @(negedge clk);
        chk("t4_rd_blk", fifo_rd_en, 0);
        chk("t4_vld0", out_valid, 0);
        step(1);
        @(negedge clk);
        chk("t4_rd_go", fifo_rd_en, 1);
        chk("t4_vld1", out_valid, 0);
        step(1);
        @(negedge clk);
        chk("t4_vld2", out_valid, 0);
        step(3);
        expect_word(32'h0000005A, 3'd1);
        pulse_flush();
        drain("t4_drain");

        // Flush while the 4th read is pending: only the full word
        expect_word(32'h88776655, 3'd4);
        load(8'h55); load(8'h66); load(8'h77); load(8'h88);
        step(4);
        pulse_flush();
        drain("t5_drain");

        // Reset mid-word with a word parked in the out register
        out_ready = 1'b0;
        load(8'hD1); load(8'hD2); load(8'hD3); load(8'hD4);
        load(8'hA1); load(8'hA2);
        step(8);
        @(negedge clk);
        chk("t6_pre_vld", out_valid, 1);
        step(1);
        rst_n = 1'b0;
        load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
        #1;
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        chk("t6_rst_vld", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_cnt", out_count, 0);
        step(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_word(32'hB4B3B2B1, 3'd4);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
